// File: rtl/unary_expand_seq.sv
// Count-to-thermometer expander: turns a count into a VWIDTH-bit LSB-first run
// of ones and streams it out as VWIDTH/BWIDTH beats under valid/ready.
module unary_expand_seq #(
   parameter int VWIDTH = 8,
   parameter int CWIDTH = 4,
   parameter int BWIDTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CWIDTH-1:0] in_count,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [BWIDTH-1:0] out_data,
   output logic              out_last,
   output logic              out_sat
);

   //  state | meaning
   //  IDLE  | waiting for a count, in_ready high
   //  EMIT  | presenting beats of the current vector, out_valid high
   localparam logic ST_IDLE = 1'b0;
   localparam logic ST_EMIT = 1'b1;

   localparam int NBEATS = VWIDTH / BWIDTH;
   localparam int BIW    = (NBEATS > 1) ? $clog2(NBEATS) : 1;

   localparam logic [CWIDTH-1:0] VW_C      = CWIDTH'(VWIDTH);
   localparam logic [CWIDTH-1:0] BW_C      = CWIDTH'(BWIDTH);
   localparam logic [BIW-1:0]    LAST_BEAT = BIW'(NBEATS - 1);

   logic              state_q, state_d;
   logic [CWIDTH-1:0] rem_q, rem_d;
   logic [BIW-1:0]    beat_q, beat_d;
   logic [BWIDTH-1:0] data_q, data_d;
   logic              last_q, last_d;
   logic              sat_q, sat_d;

   logic [CWIDTH-1:0] accept_rem;
   logic [CWIDTH-1:0] rem_step;
   logic [CWIDTH-1:0] rem_nxt;
   logic [BIW-1:0]    beat_nxt;

   function automatic logic [BWIDTH-1:0] therm(input logic [CWIDTH-1:0] r);
      logic [BWIDTH-1:0] v;
      v = '0;
      for (int j = 0; j < BWIDTH; j++) begin
         v[j] = (j < int'(r));
      end
      return v;
   endfunction

   always_comb begin
      accept_rem = (in_count > VW_C) ? VW_C : in_count;
      rem_step   = (rem_q > BW_C) ? BW_C : rem_q;
      rem_nxt    = rem_q - rem_step;
      beat_nxt   = beat_q + 1'b1;

      state_d = state_q;
      rem_d   = rem_q;
      beat_d  = beat_q;
      data_d  = data_q;
      last_d  = last_q;
      sat_d   = sat_q;

      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               state_d = ST_EMIT;
               rem_d   = accept_rem;
               beat_d  = '0;
               data_d  = therm(accept_rem);
               last_d  = (LAST_BEAT == '0);
               sat_d   = (in_count > VW_C);
            end
         end
         ST_EMIT: begin
            if (out_ready) begin
               if (last_q) begin
                  state_d = ST_IDLE;
                  rem_d   = '0;
                  beat_d  = '0;
                  data_d  = '0;
                  last_d  = 1'b0;
                  sat_d   = 1'b0;
               end else begin
                  // next beat is precomputed so outputs stay registered
                  rem_d  = rem_nxt;
                  beat_d = beat_nxt;
                  data_d = therm(rem_nxt);
                  last_d = (beat_nxt == LAST_BEAT);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         rem_q   <= '0;
         beat_q  <= '0;
         data_q  <= '0;
         last_q  <= 1'b0;
         sat_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         beat_q  <= beat_d;
         data_q  <= data_d;
         last_q  <= last_d;
         sat_q   <= sat_d;
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_EMIT);
   assign out_data  = data_q;
   assign out_last  = last_q;
   assign out_sat   = sat_q;

endmodule

// File: tb/tb_unary_expand_seq.sv
// Scoreboard bench for unary_expand_seq: accepted counts push expected beats,
// a monitor pops and compares whenever a beat is presented.
module tb_unary_expand_seq;

   localparam int VW = 8;
   localparam int BW = 4;
   localparam int NB = VW / BW;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_count;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] out_data;
   logic       out_last;
   logic       out_sat;

   typedef struct {
      logic [3:0] data;
      logic       last;
      logic       sat;
   } beat_t;

   beat_t exp_q[$];
   int    exp_ones[$];
   int    acc_cyc[$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int ones_acc = 0;
   int idle_cnt = 0;
   bit rand_ready = 0;

   unary_expand_seq #(.VWIDTH(8), .CWIDTH(4), .BWIDTH(4)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_count(in_count),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_last(out_last), .out_sat(out_sat)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Reference: thermometer of min(c,VW) ones, sliced into beats.
   task automatic push_exp(input logic [3:0] c);
      int r;
      logic [VW-1:0] vec;
      beat_t e;
      r = (int'(c) > VW) ? VW : int'(c);
      vec = VW'((1 << r) - 1);
      for (int b = 0; b < NB; b++) begin
         e.data = vec[b*BW +: BW];
         e.last = (b == NB - 1);
         e.sat  = (int'(c) > VW);
         exp_q.push_back(e);
      end
      exp_ones.push_back(r);
   endtask

   always @(negedge clk) begin
      if (!rst && in_valid && in_ready) begin
         push_exp(in_count);
         acc_cyc.push_back(cyc);
      end
   end

   always @(negedge clk) begin
      beat_t e;
      if (rst) begin
         ones_acc = 0;
         idle_cnt = 0;
      end else begin
         checks++;
         if (in_ready === out_valid) begin
            errors++;
            $display("FAIL handshake in_ready=%b out_valid=%b", in_ready, out_valid);
         end
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_beat got data=%b want no beat", out_data);
            end else begin
               e = exp_q[0];
               checks++;
               if (out_data !== e.data || out_last !== e.last || out_sat !== e.sat) begin
                  errors++;
                  $display("FAIL %s got data=%b last=%b sat=%b want data=%b last=%b sat=%b",
                           out_ready ? "beat" : "hold", out_data, out_last, out_sat,
                           e.data, e.last, e.sat);
               end
               if (out_ready) begin
                  void'(exp_q.pop_front());
                  ones_acc += $countones(out_data);
                  if (out_last && exp_ones.size() > 0) begin
                     checks++;
                     if (ones_acc != exp_ones[0]) begin
                        errors++;
                        $display("FAIL popcount got %0d want %0d", ones_acc, exp_ones[0]);
                     end
                     void'(exp_ones.pop_front());
                     ones_acc = 0;
                  end
               end
            end
         end
         if (exp_q.size() > 0 && !out_valid) idle_cnt++;
         else idle_cnt = 0;
         if (idle_cnt > 1) begin
            checks++; errors++;
            $display("FAIL latency got no beat after %0d cycles want 1", idle_cnt);
            exp_q.delete(); exp_ones.delete(); idle_cnt = 0; ones_acc = 0;
         end
      end
   end

   always @(posedge clk) begin
      #1;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
   end

   task automatic offer(input logic [3:0] c);
      bit got;
      int k;
      got = 0;
      k = 0;
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_count = c;
      while (!got && k < 100) begin
         @(negedge clk);
         if (in_ready) got = 1;
         k++;
      end
      if (!got) begin
         checks++; errors++;
         $display("FAIL accept_timeout got in_ready=0 want 1 count=%0d", c);
      end
   endtask

   task automatic drop();
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int k;
      k = 0;
      while ((exp_q.size() > 0 || out_valid) && k < 200) begin
         @(negedge clk);
         k++;
      end
      if (k >= 200) begin
         checks++; errors++;
         $display("FAIL drain_timeout got %0d beats pending want 0", exp_q.size());
         exp_q.delete(); exp_ones.delete();
      end
   endtask

   initial begin
      logic [3:0] dir_counts[5];
      dir_counts[0] = 4'd0; dir_counts[1] = 4'd1; dir_counts[2] = 4'd5;
      dir_counts[3] = 4'd8; dir_counts[4] = 4'd15;

      rst = 1'b1; in_valid = 1'b0; in_count = '0; out_ready = 1'b1;
      #23;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 4'b0 ||
          out_last !== 1'b0 || out_sat !== 1'b0) begin
         errors++;
         $display("FAIL reset got v=%b r=%b d=%b l=%b s=%b want v=0 r=1 d=0000 l=0 s=0",
                  out_valid, in_ready, out_data, out_last, out_sat);
      end
      @(negedge clk); rst = 1'b0;

      foreach (dir_counts[i]) begin
         offer(dir_counts[i]);
         drop();
         drain();
      end

      // Backpressure on the first beat of count 6.
      out_ready = 1'b0;
      offer(4'd6);
      drop();
      repeat (3) @(negedge clk);
      @(posedge clk); #1; out_ready = 1'b1;
      drain();

      // Back-to-back with in_valid held.
      acc_cyc.delete();
      offer(4'd3);
      offer(4'd7);
      drop();
      drain();
      checks++;
      if (acc_cyc.size() != 2 || (acc_cyc[1] - acc_cyc[0]) != NB + 1) begin
         errors++;
         $display("FAIL throughput got %0d accepts spacing %0d want 2 spacing %0d",
                  acc_cyc.size(), (acc_cyc.size() == 2) ? acc_cyc[1] - acc_cyc[0] : -1, NB + 1);
      end

      // Reset in the middle of a vector.
      offer(4'd7);
      drop();
      begin
         int k;
         k = 0;
         while (!(out_valid && out_ready) && k < 20) begin
            @(negedge clk);
            k++;
         end
      end
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 4'b0) begin
         errors++;
         $display("FAIL async_reset got v=%b r=%b d=%b want v=0 r=1 d=0000",
                  out_valid, in_ready, out_data);
      end
      exp_q.delete(); exp_ones.delete(); ones_acc = 0;
      #1; rst = 1'b0;
      offer(4'd2);
      drop();
      drain();

      // Randomized counts, gaps and backpressure.
      rand_ready = 1;
      for (int n = 0; n < 40; n++) begin
         offer(4'($urandom_range(0, 15)));
         if ($urandom_range(0, 3) == 0) begin
            drop();
            repeat ($urandom_range(0, 3)) @(posedge clk);
         end
      end
      drop();
      drain();
      rand_ready = 0;
      #1; out_ready = 1'b1;
      repeat (3) @(posedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/unary_expand_seq.md
Name: unary_expand_seq

Overview:
- Inverse of the popcount stage in the BNN datapath: takes a count value and produces a VWIDTH-bit vector containing exactly that many ones, packed LSB-first as a thermometer code.
- The vector is streamed out in VWIDTH/BWIDTH beats of BWIDTH bits each, using valid/ready on both sides.
- Used to regenerate binarized activation/weight vectors from counts, and as a stimulus source for popcount verification, where popcount(output vector) must equal the saturated count.

Parameters:
- VWIDTH, 8, total vector width in bits; must be a multiple of BWIDTH.
- CWIDTH, 4, count input width; must satisfy 2^CWIDTH-1 >= VWIDTH.
- BWIDTH, 4, output beat width in bits.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, asynchronous active-high reset.
- in_valid, input, 1, count available.
- in_ready, output, 1, block can accept a count.
- in_count, input, CWIDTH, requested number of ones.
- out_valid, output, 1, beat valid.
- out_ready, input, 1, downstream accepts beat.
- out_data, output, BWIDTH, current beat; beat 0 holds vector bits [BWIDTH-1:0].
- out_last, output, 1, high on final beat of a vector.
- out_sat, output, 1, high on all beats of a vector whose in_count > VWIDTH.

Behaviour:
- Reset (async, rst=1): state IDLE, in_ready=1, out_valid=0, out_data=0, out_last=0, out_sat=0, beat index=0, remaining=0.
- FSM has two states, IDLE and EMIT.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&in_ready at a clock edge: latch rem=min(in_count,VWIDTH) and sat=(in_count>VWIDTH); beat index=0; go to EMIT.
- EMIT:
  - in_ready=0; out_valid=1 on the cycle after acceptance, so latency from accept to first valid beat is 1 cycle.
  - out_data bit j = 1 iff j < rem_cur, where rem_cur = ones still to emit, saturated to BWIDTH for the beat (all ones if rem_cur>=BWIDTH, zero beat if rem_cur=0).
  - out_last=1 when beat index = VWIDTH/BWIDTH-1.
  - out_data, out_last and out_sat are registered and held stable while out_valid&!out_ready (no change under backpressure).
  - On out_valid&out_ready: rem_cur -= min(rem_cur,BWIDTH); beat index += 1.
  - If the accepted beat had out_last=1: return to IDLE (out_valid=0 the next cycle).
- No input acceptance during EMIT, so one vector is in flight at a time. Throughput is VWIDTH/BWIDTH+1 cycles per vector at full out_ready.
- Always exactly VWIDTH/BWIDTH beats per vector, including count 0 (all-zero beats).
- Total ones across the beats equals min(in_count,VWIDTH).
- Width rules: rem_cur is CWIDTH bits. Comparisons are unsigned. The subtraction never underflows.
- rst asserted mid-vector: output aborts immediately to reset values; the partial vector is discarded, and the next accepted count restarts at beat 0.
- in_valid held high while in EMIT: the count is not consumed; it is accepted in the first IDLE cycle.

Test Plan:
- Reset then in_count=0 -> 2 beats 4'b0000, 4'b0000; out_last on beat 2; out_sat=0.
- in_count=1 -> beats 4'b0001, 4'b0000. in_count=5 -> 4'b1111, 4'b0001. in_count=8 -> 4'b1111, 4'b1111; out_sat=0.
- in_count=15 (>VWIDTH) -> 4'b1111, 4'b1111; out_sat=1 on both beats.
- Backpressure: in_count=6, out_ready low 3 cycles on beat 1 -> out_data holds 4'b1111 stable with out_valid=1; then 4'b0011 with out_last; in_ready stays 0 until return to IDLE.
- Back-to-back: in_valid held high with counts 3 then 7, out_ready=1 -> beats 0111, 0000, 1111, 0111; second count accepted only in IDLE; 3 cycles per vector.
- rst pulse after first beat of in_count=7 -> out_valid=0 and in_ready=1 asynchronously; next in_count=2 yields 0011, 0000.
- Cross-check in all cases: popcount of the concatenated beats equals min(in_count,8).
